// File: rtl/data_write_buffer.sv
// Store buffer between the M stage and data memory.
// Stores are queued in program order in a circular FIFO and drained to memory
// via a valid/ready handshake. Loads that touch a word held in the buffer, or
// the word being stored in the same cycle, stall the pipeline until it drains.
module data_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               in_byteen,
    input  logic [31:0]              in_addr,
    input  logic [31:0]              in_wdata,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    output logic                     stall,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [3:0]               mem_byteen,
    output logic [31:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   addr_q   [DEPTH];
    logic [3:0]    byteen_q [DEPTH];
    logic [31:0]   wdata_q  [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    logic          st_req;
    logic          full;
    logic          enq;
    logic          deq;
    logic          buf_hit;
    logic          in_hit;
    logic          ld_hazard;
    logic [PW-1:0] offs;

    assign st_req     = (in_byteen != 4'b0000);
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign mem_valid  = !empty;
    // Room is judged on the pre-dequeue count: a full buffer refuses a store
    // even when the head drains in the same cycle.
    assign enq        = st_req && !full;
    assign deq        = mem_valid && mem_ready;

    assign mem_addr   = addr_q[rp];
    assign mem_byteen = byteen_q[rp];
    assign mem_wdata  = wdata_q[rp];

    assign in_hit     = st_req && (in_addr[31:2] == ld_addr[31:2]);
    assign ld_hazard  = ld_req && (buf_hit || in_hit);
    assign stall      = (st_req && full) || ld_hazard;

    // Word-address match of the load against every occupied entry; an entry
    // is occupied when its distance from the read pointer is below count.
    always_comb begin
        buf_hit = 1'b0;
        offs    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rp;
            if (({1'b0, offs} < count) && (addr_q[i][31:2] == ld_addr[31:2])) begin
                buf_hit = 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wp]   <= in_addr;
            byteen_q[wp] <= in_byteen;
            wdata_q[wp]  <= in_wdata;
        end
    end

    // Pointers and occupancy counter; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wp <= wp + 1'b1;
            end
            if (deq) begin
                rp <= rp + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/data_write_buffer.md
DATA_WRITE_BUFFER -- requirements
Module: data_write_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, meaning the number of store entries; it SHALL be a power of two, minimum 2.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port in_byteen  input  4  store byte enables from the M-stage byte-enable stage; 4'b0000 means no store this cycle.
REQ-005 SHALL provide port in_addr  input  32  store byte address.
REQ-006 SHALL provide port in_wdata  input  32  lane-aligned store data.
REQ-007 SHALL provide port ld_req  input  1  an M-stage load is being issued this cycle.
REQ-008 SHALL provide port ld_addr  input  32  load byte address.
REQ-009 SHALL provide port stall  output  1  freezes the pipeline M stage and earlier.
REQ-010 SHALL provide port mem_valid  output  1  head entry presented to data memory.
REQ-011 SHALL provide port mem_ready  input  1  memory accepts the presented write.
REQ-012 SHALL provide port mem_addr / mem_byteen / mem_wdata  output  32/4/32  head entry fields.
REQ-013 SHALL provide port count  output  clog2(DEPTH)+1  number of occupied entries.
REQ-014 SHALL provide port empty  output  1  count == 0.

Function
REQ-015 SHALL be a circular FIFO with write pointer wp, read pointer rp and counter count; pointers SHALL wrap modulo DEPTH.
REQ-016 Enqueue SHALL occur when in_byteen != 0 and count < DEPTH (evaluated before any same-cycle dequeue); the entry {in_addr, in_byteen, in_wdata} SHALL be written at wp, and wp SHALL increment.
REQ-017 When in_byteen != 0 and count == DEPTH, the store SHALL NOT enqueue even if a dequeue occurs in the same cycle; stall SHALL be 1 for that cycle.
REQ-018 mem_valid SHALL equal !empty; mem_addr, mem_byteen and mem_wdata SHALL show entry[rp], and SHALL hold stable while mem_valid=1 and mem_ready=0.
REQ-019 Dequeue SHALL occur when mem_valid && mem_ready; rp SHALL increment.
REQ-020 On simultaneous enqueue and dequeue, count SHALL remain unchanged and both pointers SHALL advance.
REQ-021 A load hazard SHALL exist when ld_req=1 and any occupied entry satisfies entry.addr[31:2] == ld_addr[31:2]; byte enables SHALL be ignored in the comparison.
REQ-022 A load hazard SHALL also exist when ld_req=1, in_byteen != 0 and in_addr[31:2] == ld_addr[31:2].
REQ-023 stall SHALL be combinational: (in_byteen != 0 && count == DEPTH) || load hazard.
REQ-024 A store presented while stall=1 for a load hazard SHALL still enqueue if there is room; the pipeline SHALL re-present it next cycle only if it was not accepted.
REQ-025 Latency: an enqueued entry SHALL appear on mem_* no earlier than the cycle after it was written (registered storage, no bypass).
REQ-026 Stores SHALL drain in program order; there SHALL be no merging or reordering.
REQ-027 mem_ready while mem_valid=0 SHALL have no effect.

Reset
REQ-028 On reset assertion, wp, rp and count SHALL go to 0 immediately; mem_valid SHALL be 0 and empty SHALL be 1; entry contents are don't-care.
REQ-029 Reset mid-drain SHALL discard all pending entries without completing any handshake.
REQ-030 After reset release, the first rising edge SHALL accept an enqueue.

Verification
REQ-031 Single store: in_byteen=4'b1111, in_addr=0x10, in_wdata=0xDEADBEEF, mem_ready=1 -> next cycle mem_valid=1 with the same fields; count goes 1 then 0.
REQ-032 Fill: with mem_ready=0, 5 consecutive stores (DEPTH=4) -> count=4; the 5th cycle has stall=1 and no enqueue; raising mem_ready drains all 4 entries in order.
REQ-033 Full with simultaneous drain: count=4, mem_ready=1, store presented -> dequeue only, count=3, stall=1; next cycle the store enqueues.
REQ-034 Load hazard: pending sb at 0x23 (byteen 4'b1000), ld_req with ld_addr=0x20 -> stall=1 until the entry drains; ld_addr=0x24 -> stall=0.
REQ-035 Backpressure: mem_ready toggling 0/1 over 6 entries -> mem_* stable while not ready, no loss, no duplicates.
REQ-036 Reset at count=3 mid-handshake -> count=0, mem_valid=0 asynchronously, before the next clock edge.
